microwave_sequencer: RTL and testbench

- Central control FSM for the microwave timer datapath.
- Sequences keypad digit entry, start, pause and cancel, door interlock, countdown enable and the end-of-cook beep.
- Drives the load/clear strobes of the time-entry/counter chain and the magnetron enable; consumes the counter's zero flag and the 1 Hz tick.
- Sits between the keypad/buttons and the entry, counter and magnetron blocks.

---
 rtl/microwave_pkg.sv | 16 +
 rtl/microwave_sequencer_beep_timer.sv | 28 ++
 rtl/microwave_sequencer.sv | 148 ++++++++++++++
 tb/tb_microwave_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared constants for the microwave timer control path: state encoding,
// digit key range and default sequencing parameters.
package microwave_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ENTRY = 3'd1;
  localparam logic [2:0] ST_COOK  = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;

  localparam int unsigned DEF_MAX_DIGITS   = 3;
  localparam int unsigned DEF_BEEP_SECONDS = 3;

endpackage

// File: rtl/microwave_sequencer_beep_timer.sv
// Tick-driven down-counter timing the end-of-cook beep; done_c is high once
// the loaded count has been consumed.
module beep_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         done_c
);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign done_c = (count == '0);

endmodule

// File: rtl/microwave_sequencer.sv
// Central control FSM of the microwave timer: keypad entry, start/pause/
// cancel, door interlock, countdown enable and end-of-cook beep.
module microwave_sequencer
  import microwave_pkg::*;
#(
  parameter int unsigned MAX_DIGITS   = DEF_MAX_DIGITS,
  parameter int unsigned BEEP_SECONDS = DEF_BEEP_SECONDS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  input  logic       tick_1hz,
  input  logic       zero,
  output logic       load_digit,
  output logic [3:0] digit_out,
  output logic       clear_time,
  output logic       count_en,
  output logic       magnetron_on,
  output logic       beep,
  output logic [2:0] state_o
);

  localparam int unsigned CNT_W  = $clog2(MAX_DIGITS + 1);
  localparam int unsigned BEEP_W = (BEEP_SECONDS > 1) ? $clog2(BEEP_SECONDS) : 1;

  logic [2:0]       state;
  logic [2:0]       state_n;
  logic [CNT_W-1:0] digit_cnt;
  logic [CNT_W-1:0] digit_cnt_n;
  logic             load_n;
  logic             clear_n;
  logic [3:0]       digit_n;
  logic             timer_load;
  logic             timer_en;
  logic             beep_done_c;
  logic             is_digit;

  assign is_digit = key_valid && (key_code <= KEY_MAX_DIGIT);

  // State and registered-output flops
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      digit_cnt  <= '0;
      load_digit <= 1'b0;
      clear_time <= 1'b0;
      beep       <= 1'b0;
      digit_out  <= 4'd0;
    end else begin
      state      <= state_n;
      digit_cnt  <= digit_cnt_n;
      load_digit <= load_n;
      clear_time <= clear_n;
      beep       <= (state_n == ST_DONE);
      digit_out  <= digit_n;
    end
  end

  // Next state; case order inside each state encodes input priority
  always_comb begin
    state_n     = state;
    digit_cnt_n = digit_cnt;
    load_n      = 1'b0;
    clear_n     = 1'b0;
    digit_n     = digit_out;
    timer_load  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (is_digit) begin
          load_n      = 1'b1;
          digit_n     = key_code;
          digit_cnt_n = CNT_W'(1);
          state_n     = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (stop) begin
          clear_n     = 1'b1;
          digit_cnt_n = '0;
          state_n     = ST_IDLE;
        end else if (start && door_closed && !zero) begin
          state_n = ST_COOK;
        end else if (is_digit && (digit_cnt < CNT_W'(MAX_DIGITS))) begin
          load_n      = 1'b1;
          digit_n     = key_code;
          digit_cnt_n = digit_cnt + CNT_W'(1);
        end
      end
      ST_COOK: begin
        if (zero) begin
          timer_load = 1'b1;
          state_n    = ST_DONE;
        end else if (stop || !door_closed) begin
          state_n = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          clear_n     = 1'b1;
          digit_cnt_n = '0;
          state_n     = ST_IDLE;
        end else if (start && door_closed) begin
          state_n = ST_COOK;
        end
      end
      ST_DONE: begin
        if (stop || key_valid || (tick_1hz && beep_done_c)) begin
          clear_n     = 1'b1;
          digit_cnt_n = '0;
          state_n     = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Zero-latency heating and countdown controls
  always_comb begin
    magnetron_on = 1'b0;
    count_en     = 1'b0;
    timer_en     = 1'b0;
    if (state == ST_COOK) begin
      magnetron_on = door_closed;
      count_en     = door_closed && tick_1hz && !zero;
    end
    if (state == ST_DONE) begin
      timer_en = tick_1hz;
    end
  end

  assign state_o = state;

  beep_timer #(
    .W(BEEP_W)
  ) u_beep_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (BEEP_W'(BEEP_SECONDS - 1)),
    .en         (timer_en),
    .done_c     (beep_done_c)
  );

endmodule

// File: tb/tb_microwave_sequencer.sv
// Self-checking bench for microwave_sequencer: directed scenarios with literal
// expectations, then randomized stimulus against a behavioural model.
module tb_microwave_sequencer;

  localparam int MAXD  = 3;
  localparam int BEEPS = 3;

  logic       clock;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic       start;
  logic       stop;
  logic       door_closed;
  logic       tick_1hz;
  logic       zero;
  logic       load_digit;
  logic [3:0] digit_out;
  logic       clear_time;
  logic       count_en;
  logic       magnetron_on;
  logic       beep;
  logic [2:0] state_o;

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 0;

  microwave_sequencer #(.MAX_DIGITS(MAXD), .BEEP_SECONDS(BEEPS)) dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .start(start), .stop(stop), .door_closed(door_closed), .tick_1hz(tick_1hz),
    .zero(zero), .load_digit(load_digit), .digit_out(digit_out),
    .clear_time(clear_time), .count_en(count_en), .magnetron_on(magnetron_on),
    .beep(beep), .state_o(state_o)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  // Behavioural model: mode 0 idle, 1 entering, 2 cooking, 3 paused, 4 done
  int       m_mode = 0;
  int       m_digits = 0;
  int       m_beeps_left = 0;
  bit       m_load = 0;
  bit       m_clear = 0;
  bit       m_beep = 0;
  int       m_digit = 0;

  always @(posedge clock) begin
    int  mode, digits, left, dig;
    bit  ld, clr, is_digit;
    mode = m_mode; digits = m_digits; left = m_beeps_left; dig = m_digit;
    ld = 0; clr = 0;
    is_digit = key_valid && (int'(key_code) <= 9);
    if (reset) begin
      mode = 0; digits = 0; left = 0; dig = 0;
    end else begin
      case (mode)
        0: if (is_digit) begin ld = 1; dig = int'(key_code); digits = 1; mode = 1; end
        1: if (stop) begin clr = 1; digits = 0; mode = 0; end
           else if (start && door_closed && !zero) mode = 2;
           else if (is_digit && digits < MAXD) begin ld = 1; dig = int'(key_code); digits++; end
        2: if (zero) begin mode = 4; left = BEEPS; end
           else if (stop || !door_closed) mode = 3;
        3: if (stop) begin clr = 1; digits = 0; mode = 0; end
           else if (start && door_closed) mode = 2;
        4: if (stop || key_valid) begin clr = 1; mode = 0; end
           else if (tick_1hz) begin
             left--;
             if (left == 0) begin clr = 1; mode = 0; end
           end
        default: mode = 0;
      endcase
    end
    m_mode       <= mode;
    m_digits     <= digits;
    m_beeps_left <= left;
    m_digit      <= dig;
    m_load       <= ld;
    m_clear      <= clr;
    m_beep       <= (mode == 4) && !reset;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clock) begin
    if (checking) begin
      check("model state_o", int'(state_o), m_mode);
      check("model load_digit", int'(load_digit), int'(m_load));
      check("model clear_time", int'(clear_time), int'(m_clear));
      check("model beep", int'(beep), int'(m_beep));
      check("model digit_out", int'(digit_out), m_digit);
      check("model magnetron_on", int'(magnetron_on), int'((m_mode == 2) && door_closed));
      check("model count_en", int'(count_en),
            int'((m_mode == 2) && door_closed && tick_1hz && !zero));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1; key_code = k;
    step();
    key_valid = 0;
    #1;
  endtask

  task automatic pulse_start();
    start = 1; step(); start = 0; #1;
  endtask

  task automatic pulse_stop();
    stop = 1; step(); stop = 0; #1;
  endtask

  task automatic pulse_tick();
    tick_1hz = 1; step(); tick_1hz = 0; #1;
  endtask

  initial begin
    reset = 1; key_valid = 0; key_code = 0; start = 0; stop = 0;
    door_closed = 0; tick_1hz = 0; zero = 0;
    step(); step();
    checking = 1;
    reset = 0;
    check("reset state", int'(state_o), 0);
    check("reset load", int'(load_digit), 0);
    check("reset clear", int'(clear_time), 0);
    check("reset beep", int'(beep), 0);
    check("reset digit_out", int'(digit_out), 0);

    // Digit entry up to the limit
    press(4'd1);
    check("key1 load", int'(load_digit), 1);
    check("key1 digit", int'(digit_out), 1);
    check("key1 state", int'(state_o), 1);
    step();
    check("load one cycle", int'(load_digit), 0);
    press(4'd3);
    check("key3 digit", int'(digit_out), 3);
    press(4'd0);
    check("key0 load", int'(load_digit), 1);
    check("key0 digit", int'(digit_out), 0);
    press(4'd5);
    check("4th key no load", int'(load_digit), 0);
    check("4th key digit held", int'(digit_out), 0);
    check("4th key state", int'(state_o), 1);

    // Start blocked while counter reads zero
    door_closed = 1; zero = 1;
    pulse_start();
    check("start zero ignored", int'(state_o), 1);
    zero = 0;
    pulse_start();
    check("cook state", int'(state_o), 2);
    check("cook magnetron", int'(magnetron_on), 1);
    tick_1hz = 1; #1;
    check("count_en on tick", int'(count_en), 1);
    step(); tick_1hz = 0; #1;
    check("count_en no tick", int'(count_en), 0);

    // Door opened mid-cook
    door_closed = 0; #1;
    check("door open magnetron", int'(magnetron_on), 0);
    step();
    check("door open pause", int'(state_o), 3);
    pulse_start();
    check("start door open", int'(state_o), 3);
    door_closed = 1;
    pulse_start();
    check("resume cook", int'(state_o), 2);

    // zero beats stop, then beep for BEEPS ticks
    zero = 1;
    pulse_stop();
    check("zero over stop", int'(state_o), 4);
    check("done beep", int'(beep), 1);
    pulse_tick();
    pulse_tick();
    check("beep after 2 ticks", int'(beep), 1);
    check("done after 2 ticks", int'(state_o), 4);
    pulse_tick();
    check("beep end state", int'(state_o), 0);
    check("beep end clear", int'(clear_time), 1);
    check("beep end beep", int'(beep), 0);
    step();
    check("clear one cycle", int'(clear_time), 0);
    zero = 0;

    // Cancel from pause restarts digit count
    press(4'd2);
    pulse_start();
    door_closed = 0;
    step();
    check("pause again", int'(state_o), 3);
    door_closed = 1;
    pulse_stop();
    check("pause stop clear", int'(clear_time), 1);
    check("pause stop idle", int'(state_o), 0);
    press(4'd4); check("re-entry 1", int'(load_digit), 1);
    press(4'd5); check("re-entry 2", int'(load_digit), 1);
    press(4'd6); check("re-entry 3", int'(load_digit), 1);
    press(4'd7); check("re-entry limit", int'(load_digit), 0);

    // Key aborts beep without loading
    pulse_start();
    zero = 1;
    step();
    check("done via zero", int'(state_o), 4);
    press(4'd7);
    check("key abort state", int'(state_o), 0);
    check("key abort beep", int'(beep), 0);
    check("key abort no load", int'(load_digit), 0);
    check("key abort clear", int'(clear_time), 1);
    zero = 0;

    // Reset mid-cook
    press(4'd1);
    pulse_start();
    check("pre-reset cook", int'(state_o), 2);
    reset = 1;
    step();
    reset = 0; #1;
    check("reset cook state", int'(state_o), 0);
    check("reset cook magnetron", int'(magnetron_on), 0);
    check("reset cook clear", int'(clear_time), 0);
    check("reset cook load", int'(load_digit), 0);
    check("reset cook beep", int'(beep), 0);

    // Randomized traffic, model checked every cycle
    for (int i = 0; i < 4000; i++) begin
      reset     = ($urandom_range(0, 299) == 0);
      key_valid = ($urandom_range(0, 5) == 0);
      key_code  = 4'($urandom_range(0, 15));
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 19) == 0);
      tick_1hz  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) door_closed = ~door_closed;
      if ($urandom_range(0, 14) == 0) zero = ~zero;
      step();
    end
    reset = 0; key_valid = 0; start = 0; stop = 0; tick_1hz = 0;
    step();
    step();
    checking = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
